// File: rtl/axis_pretrigger_capture.sv
// axis_pretrigger_capture: keeps a rolling window of cfg_pre samples in a ring
// buffer and, once triggered, streams a record of exactly cfg_total samples
// (stored pre-trigger window first, then live data) with tlast on the last one.
//
// Handshake semantics: a beat transfers on a rising edge where valid and ready
// are both high; a master holds valid and data stable until that edge, and
// ready may depend on the receiver's registered state only.
module axis_pretrigger_capture #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int BUF_ADDR_WIDTH   = 10,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [BUF_ADDR_WIDTH-1:0]   cfg_pre,
   input  logic [CNTR_WIDTH-1:0]       cfg_total,
   input  logic                        arm,
   input  logic                        trigger,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic [1:0]                  sts_state,
   output logic                        done
);

   localparam int DEPTH = 2 ** BUF_ADDR_WIDTH;
   localparam logic [BUF_ADDR_WIDTH:0]   FILL_FULL = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};
   localparam logic [BUF_ADDR_WIDTH:0]   FILL_ONE  = 1;
   localparam logic [BUF_ADDR_WIDTH-1:0] PTR_ONE   = 1;
   localparam logic [CNTR_WIDTH-1:0]     CNT_ONE   = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRETRIG = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t                        state_q, state_d;
   logic [BUF_ADDR_WIDTH-1:0]     pre_q, pre_d;
   logic [CNTR_WIDTH-1:0]         total_q, total_d;
   logic                          trig_q, trig_d;
   logic                          first_q, first_d;
   logic [BUF_ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
   logic [BUF_ADDR_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
   logic [BUF_ADDR_WIDTH:0]       fill_q, fill_d;
   logic [CNTR_WIDTH-1:0]         wr_cnt_q, wr_cnt_d;
   logic [CNTR_WIDTH-1:0]         out_cnt_q, out_cnt_d;
   logic [AXIS_TDATA_WIDTH-1:0]   m_data_q, m_data_d;
   logic                          m_valid_q, m_valid_d;
   logic                          m_last_q, m_last_d;

   logic [AXIS_TDATA_WIDTH-1:0]   mem [DEPTH];

   logic in_hs, out_hs, fire, cap_open, wr_en, drop, load, pop;

   // Capture keeps accepting input until the record has all its samples;
   // afterwards surplus input is discarded with ready held high.
   assign cap_open      = (wr_cnt_q < total_q);
   assign s_axis_tready = !((state_q == ST_CAPTURE) && cap_open && (fill_q == FILL_FULL));
   assign in_hs         = s_axis_tvalid && s_axis_tready;
   assign out_hs        = m_valid_q && m_axis_tready;

   // Trigger fires only once the window holds exactly cfg_pre samples, so the
   // sample presented in the firing cycle is the trigger sample itself.
   assign fire  = (state_q == ST_PRETRIG) && (trig_q || trigger) && (fill_q == {1'b0, pre_q});
   assign drop  = in_hs && (state_q == ST_PRETRIG) && !fire && (fill_q == {1'b0, pre_q});
   assign wr_en = in_hs && (((state_q == ST_PRETRIG) && !fire)
                         || (fire && (CNTR_WIDTH'(pre_q) < total_q))
                         || ((state_q == ST_CAPTURE) && cap_open));
   // The output register doubles as the ring read register (1-cycle read).
   assign load  = (state_q == ST_CAPTURE) && !first_q && (fill_q != '0)
               && (out_cnt_q < total_q) && (!m_valid_q || m_axis_tready);
   assign pop   = load || drop;

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;
   assign sts_state     = state_q;
   assign done          = (state_q == ST_DONE);

   // Next-state and datapath computation for every register of the block.
   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      total_d   = total_q;
      trig_d    = trig_q;
      first_d   = 1'b0;
      wr_cnt_d  = wr_cnt_q;
      out_cnt_d = out_cnt_q;
      wr_ptr_d  = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({wr_en, pop})
         2'b10:   fill_d = fill_q + FILL_ONE;
         2'b01:   fill_d = fill_q - FILL_ONE;
         default: fill_d = fill_q;
      endcase
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      if (load) begin
         m_data_d  = mem[rd_ptr_q];
         m_valid_d = 1'b1;
         m_last_d  = ((out_cnt_q + CNT_ONE) == total_q);
         out_cnt_d = out_cnt_q + CNT_ONE;
      end else if (out_hs) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               pre_d     = cfg_pre;
               total_d   = cfg_total;
               trig_d    = 1'b0;
               wr_ptr_d  = '0;
               rd_ptr_d  = '0;
               fill_d    = '0;
               wr_cnt_d  = '0;
               out_cnt_d = '0;
               state_d   = (cfg_total == '0) ? ST_DONE : ST_PRETRIG;
            end
         end
         ST_PRETRIG: begin
            if (trigger) trig_d = 1'b1;
            if (fire) begin
               state_d  = ST_CAPTURE;
               first_d  = 1'b1;
               trig_d   = 1'b0;
               wr_cnt_d = CNTR_WIDTH'(pre_q) + CNTR_WIDTH'(wr_en);
            end
         end
         default: begin
            if (wr_en) wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (out_hs && m_last_q) begin
               state_d  = ST_DONE;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               fill_d   = '0;
            end
         end
      endcase
   end

   // State and control registers with synchronous active-high reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q   <= ST_IDLE;
         pre_q     <= '0;
         total_q   <= '0;
         trig_q    <= 1'b0;
         first_q   <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fill_q    <= '0;
         wr_cnt_q  <= '0;
         out_cnt_q <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         total_q   <= total_d;
         trig_q    <= trig_d;
         first_q   <= first_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         fill_q    <= fill_d;
         wr_cnt_q  <= wr_cnt_d;
         out_cnt_q <= out_cnt_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
      end
   end

   // Ring storage write port; contents need no reset.
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr_q] <= s_axis_tdata;
   end

endmodule

// File: tb/tb_axis_pretrigger_capture.sv
// Bench for axis_pretrigger_capture: table-driven ramp records, hand-written
// reset and zero-length sequences, and randomized records checked against a
// window/record reference model.
module tb_axis_pretrigger_capture;

   localparam int W  = 32;
   localparam int AW = 4;
   localparam int CW = 32;

   logic          aclk = 1'b0;
   logic          areset;
   logic [AW-1:0] cfg_pre;
   logic [CW-1:0] cfg_total;
   logic          arm, trigger;
   logic [W-1:0]  s_axis_tdata;
   logic          s_axis_tvalid, s_axis_tready;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic [1:0]    sts_state;
   logic          done;

   always #5 aclk = ~aclk;

   axis_pretrigger_capture #(
      .AXIS_TDATA_WIDTH(W), .BUF_ADDR_WIDTH(AW), .CNTR_WIDTH(CW)
   ) dut (
      .aclk(aclk), .areset(areset), .cfg_pre(cfg_pre), .cfg_total(cfg_total),
      .arm(arm), .trigger(trigger),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .sts_state(sts_state), .done(done)
   );

   typedef struct { logic trig; logic acc; logic [W-1:0] data; } cyc_t;
   typedef struct { logic [W-1:0] data; logic last; } beat_t;
   typedef struct { int pre; int total; int trig_cyc; bit pulse; int trdy_pct; int exp_first; } vec_t;

   cyc_t          cyc_log[$];
   beat_t         out_q[$];
   logic [W-1:0]  exp_q[$];
   int            n_checks = 0;
   int            n_err    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: a sliding window of the last cfg_pre accepted samples; the
   // record is that window plus samples accepted from the trigger cycle on.
   function automatic void build_exp(input int pre, input int total);
      logic [W-1:0] win[$];
      bit seen;
      bit fired;
      seen = 0;
      fired = 0;
      exp_q.delete();
      foreach (cyc_log[c]) begin
         if (!fired) begin
            seen = seen | cyc_log[c].trig;
            if (seen && win.size() >= pre) begin
               fired = 1;
               exp_q = win;
            end
         end
         if (fired) begin
            if (cyc_log[c].acc && exp_q.size() < total) exp_q.push_back(cyc_log[c].data);
         end else if (cyc_log[c].acc) begin
            win.push_back(cyc_log[c].data);
            if (win.size() > pre) void'(win.pop_front());
         end
      end
      while (exp_q.size() > total) void'(exp_q.pop_back());
   endfunction

   // Driver + monitor for one record: arm in cycle 0, then run until the
   // cycle after tlast (or abort after a number of beats).
   task automatic run_record(input int pre, input int total, input int trig_cyc, input bit pulse,
                             input int trdy_pct, input bit rnd_src, input int abort_after,
                             output bit saw_stall);
      int ramp, last_cyc;
      bit got_last, fin, prev_stall, in_hs, out_hs;
      logic [W-1:0] prev_data;
      logic prev_last;
      cyc_t cy;
      beat_t bt;
      cyc_log.delete();
      out_q.delete();
      ramp = 0; last_cyc = 0; got_last = 0; fin = 0; prev_stall = 0; saw_stall = 0;
      prev_data = '0; prev_last = 1'b0;
      @(posedge aclk); #1;
      cfg_pre = AW'(pre);
      cfg_total = CW'(total);
      arm = 1'b1;
      trigger = (trig_cyc == 0);
      if (rnd_src) begin
         s_axis_tvalid = ($urandom_range(0, 99) < 70);
         s_axis_tdata = $urandom;
      end else begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata = '0;
      end
      m_axis_tready = ($urandom_range(0, 99) < trdy_pct);
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(negedge aclk);
         in_hs = s_axis_tvalid && s_axis_tready;
         out_hs = m_axis_tvalid && m_axis_tready;
         if (i > 0) begin
            cy.trig = trigger; cy.acc = in_hs; cy.data = s_axis_tdata;
            cyc_log.push_back(cy);
            if (!s_axis_tready) saw_stall = 1;
         end
         if (i == 1) begin
            chk("armed_state", sts_state, 2'd1);
            chk("armed_done_low", done, 1'b0);
         end
         if (prev_stall) begin
            chk("tvalid_hold", m_axis_tvalid, 1'b1);
            chk("tdata_hold", m_axis_tdata, prev_data);
            chk("tlast_hold", m_axis_tlast, prev_last);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data = m_axis_tdata;
         prev_last = m_axis_tlast;
         if (got_last && i == last_cyc + 1) begin
            chk("done_after_tlast", done, 1'b1);
            chk("state_done", sts_state, 2'd3);
            fin = 1;
         end
         if (out_hs) begin
            bt.data = m_axis_tdata; bt.last = m_axis_tlast;
            out_q.push_back(bt);
            if (m_axis_tlast && !got_last) begin
               got_last = 1;
               last_cyc = i;
            end
         end
         if (abort_after > 0 && out_q.size() == abort_after) fin = 1;
         if (!fin) begin
            @(posedge aclk); #1;
            if (i == 0) begin
               arm = 1'b0;
               cfg_pre = AW'($urandom);
               cfg_total = $urandom;
            end
            trigger = pulse ? (i + 1 == trig_cyc) : (i + 1 >= trig_cyc);
            if (rnd_src) begin
               if (in_hs || !s_axis_tvalid) begin
                  s_axis_tvalid = ($urandom_range(0, 99) < 70);
                  s_axis_tdata = $urandom;
               end
            end else if (in_hs) begin
               ramp++;
               s_axis_tdata = ramp;
            end
            m_axis_tready = ($urandom_range(0, 99) < trdy_pct);
         end
      end
      trigger = 1'b0;
      s_axis_tvalid = 1'b0;
      if (!fin) begin
         n_checks++;
         n_err++;
         $display("FAIL record_timeout: got %0d beats, no completion within budget", out_q.size());
      end
      if (abort_after == 0) begin
         build_exp(pre, total);
         chk("beat_count", out_q.size(), exp_q.size());
         for (int k = 0; k < out_q.size() && k < exp_q.size(); k++) begin
            chk("beat_data", out_q[k].data, exp_q[k]);
            chk("beat_last", out_q[k].last, (k == exp_q.size() - 1));
         end
      end
   endtask

   task automatic pulse_reset();
      @(posedge aclk); #1;
      areset = 1'b1;
      @(posedge aclk); #1;
      areset = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge aclk);
      chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
      chk({tag, "_tlast"}, m_axis_tlast, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_state"}, sts_state, 2'd0);
      chk({tag, "_s_tready"}, s_axis_tready, 1'b1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[9];
      bit stall, saw_done, saw_valid, pl;
      int p, t, tc, rdy;

      vecs[0] = '{4, 10, 20, 0, 100, 16};
      vecs[1] = '{4, 10, 0, 0, 100, 1};
      vecs[2] = '{8, 100, 30, 0, 30, 22};
      vecs[3] = '{6, 3, 20, 0, 100, 14};
      vecs[4] = '{4, 10, 20, 0, 100, 16};
      vecs[5] = '{0, 5, 10, 0, 100, 10};
      vecs[6] = '{15, 20, 30, 0, 50, 15};
      vecs[7] = '{3, 3, 10, 0, 100, 7};
      vecs[8] = '{5, 12, 3, 1, 100, 1};

      areset = 1'b1; cfg_pre = '0; cfg_total = '0; arm = 1'b0; trigger = 1'b0;
      s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;
      check_idle("reset");

      foreach (vecs[r]) begin
         run_record(vecs[r].pre, vecs[r].total, vecs[r].trig_cyc, vecs[r].pulse,
                    vecs[r].trdy_pct, 1'b0, 0, stall);
         chk("row_len", out_q.size(), vecs[r].total);
         for (int k = 0; k < out_q.size(); k++)
            chk("row_data", out_q[k].data, vecs[r].exp_first + k);
         if (vecs[r].trdy_pct <= 30) chk("row_tready_stall", stall, 1'b1);
      end

      // Abandon a record after 5 of 10 beats, then re-arm for a fresh record.
      run_record(4, 10, 20, 0, 100, 1'b0, 5, stall);
      pulse_reset();
      check_idle("midreset");
      run_record(4, 10, 20, 0, 100, 1'b0, 0, stall);
      chk("rearm_len", out_q.size(), 10);
      for (int k = 0; k < out_q.size(); k++) chk("rearm_data", out_q[k].data, 16 + k);

      // Zero-length record from IDLE: DONE quickly, never any output beat.
      pulse_reset();
      check_idle("pre_zero");
      @(posedge aclk); #1;
      cfg_pre = 4'd4; cfg_total = '0; arm = 1'b1;
      saw_done = 0; saw_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         if (i == 2) saw_done = done;
         if (m_axis_tvalid) saw_valid = 1;
         @(posedge aclk); #1;
         arm = 1'b0;
      end
      chk("zero_total_done", saw_done, 1'b1);
      chk("zero_total_no_tvalid", saw_valid, 1'b0);

      // Randomized records against the reference model.
      for (int n = 0; n < 12; n++) begin
         p = $urandom_range(0, 15);
         t = $urandom_range(1, 40);
         pl = $urandom_range(0, 1);
         tc = pl ? $urandom_range(1, 30) : $urandom_range(0, 30);
         rdy = $urandom_range(20, 100);
         run_record(p, t, tc, pl, rdy, 1'b1, 0, stall);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
